// File: rtl/disp_capture.sv
// Rebuilds the scanned 4-digit display word (Hexs/point/LES) from the AN/Hex/p/LE pins.
// Latency: a digit held steady from edge t0 is captured at edge t0+STABLE_CYC; frame outputs update on that edge.
// Backpressure: none; pins are sampled every cycle and results are presented as pulses/levels.
module disp_capture #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  AN,
  input  logic [3:0]  Hex,
  input  logic        p,
  input  logic        LE,
  output logic [15:0] Hexs,
  output logic [3:0]  point,
  output logic [3:0]  LES,
  output logic        frame_valid,
  output logic [3:0]  seen,
  output logic        err_illegal,
  output logic        stalled
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // Sample register and glitch-filter run counter
  logic [9:0]    samp;
  logic [9:0]    samp_in;
  logic [SW-1:0] stab_cnt;

  // Per-slot shadows for the frame in progress
  logic [15:0]   sh_hex;
  logic [3:0]    sh_p;
  logic [3:0]    sh_le;

  // Cycles since the last legal capture
  logic [TW-1:0] idle_cnt;

  logic          same;
  logic          cap;
  logic [3:0]    slot;
  logic          is_blank;
  logic          cap_legal;
  logic          cap_illegal;
  logic          timeout_hit;
  logic [15:0]   nxt_hex;
  logic [3:0]    nxt_p;
  logic [3:0]    nxt_le;
  logic [3:0]    nxt_seen;

  assign samp_in = {AN, Hex, p, LE};
  assign same    = (samp_in == samp);
  // Capture fires exactly once per stable run, on the edge the counter reaches STABLE_CYC.
  assign cap     = same && (stab_cnt == SW'(STABLE_CYC - 1));

  // Decode the captured AN code and merge the current digit into the shadow view
  always_comb begin
    slot     = 4'b0000;
    is_blank = 1'b0;
    case (samp[9:6])
      4'b1110: slot = 4'b0001;
      4'b1101: slot = 4'b0010;
      4'b1011: slot = 4'b0100;
      4'b0111: slot = 4'b1000;
      4'b1111: is_blank = 1'b1;
      default: slot = 4'b0000;
    endcase
    cap_legal   = cap && (slot != 4'b0000);
    cap_illegal = cap && (slot == 4'b0000) && !is_blank;
    // A legal capture on the timeout edge takes priority over the timeout.
    timeout_hit = !cap_legal && (idle_cnt == TW'(TIMEOUT_CYC - 1));
    nxt_hex  = sh_hex;
    nxt_p    = sh_p;
    nxt_le   = sh_le;
    nxt_seen = seen | slot;
    for (int k = 0; k < 4; k++) begin
      if (slot[k]) begin
        nxt_hex[4*k +: 4] = samp[5:2];
        nxt_p[k]          = samp[1];
        nxt_le[k]         = samp[0];
      end
    end
  end

  // Sample the pins and count how long the sample has stayed identical
  always_ff @(posedge clk) begin
    if (rst) begin
      samp     <= {4'b1111, 6'b000000};
      stab_cnt <= '0;
    end else begin
      samp <= samp_in;
      if (!same) begin
        stab_cnt <= '0;
      end else if (stab_cnt != SW'(STABLE_CYC)) begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

  // Accumulate digits into the shadows and publish a frame once all four slots are seen
  always_ff @(posedge clk) begin
    if (rst) begin
      Hexs        <= '0;
      point       <= '0;
      LES         <= '0;
      frame_valid <= 1'b0;
      seen        <= '0;
      err_illegal <= 1'b0;
      sh_hex      <= '0;
      sh_p        <= '0;
      sh_le       <= '0;
    end else begin
      frame_valid <= 1'b0;
      err_illegal <= cap_illegal;
      if (cap_legal) begin
        sh_hex <= nxt_hex;
        sh_p   <= nxt_p;
        sh_le  <= nxt_le;
        if (nxt_seen == 4'b1111) begin
          Hexs        <= nxt_hex;
          point       <= nxt_p;
          LES         <= nxt_le;
          frame_valid <= 1'b1;
          seen        <= '0;
        end else begin
          seen <= nxt_seen;
        end
      end else if (timeout_hit) begin
        // Stall drops whatever partial frame was being assembled.
        seen <= '0;
      end
    end
  end

  // Track idle time since the last legal capture and flag a stalled scan
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      stalled  <= 1'b0;
    end else if (cap_legal) begin
      idle_cnt <= '0;
      stalled  <= 1'b0;
    end else begin
      if (idle_cnt != TW'(TIMEOUT_CYC)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (timeout_hit) begin
        stalled <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_disp_capture.sv
// Bench for disp_capture: directed scenarios plus random scan segments, scoreboarded
// against a segment-level model (a run of identical pin values held long enough yields one capture).
module tb_disp_capture;
  localparam int SC = 4;
  localparam int TO = 150;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  AN, Hex;
  logic        p, LE;
  logic [15:0] Hexs;
  logic [3:0]  point, LES, seen;
  logic        frame_valid, err_illegal, stalled;

  disp_capture #(.STABLE_CYC(SC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .AN(AN), .Hex(Hex), .p(p), .LE(LE),
    .Hexs(Hexs), .point(point), .LES(LES), .frame_valid(frame_valid),
    .seen(seen), .err_illegal(err_illegal), .stalled(stalled)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          t;
    logic [15:0] hexs;
    logic [3:0]  pt;
    logic [3:0]  les;
  } frame_t;

  frame_t fq[$];
  int     eq[$];
  frame_t fpop;
  int     epop;

  // Model state: current run of identical pin values, plus the frame being assembled
  logic [9:0] m_cur;
  int         m_t0;
  bit         m_cap;
  logic [3:0] m_seen;
  logic [3:0] m_hex[4];
  logic       m_p[4];
  logic       m_le[4];
  int         m_last;

  logic [3:0] ill_codes[8] = '{4'b0000, 4'b1100, 4'b0011, 4'b1010,
                               4'b0101, 4'b0110, 4'b1001, 4'b1000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // A capture at edge T of the value v, applied to the model
  task automatic model_capture(input int T, input logic [9:0] v);
    int k;
    frame_t f;
    k = -1;
    if (v[9:6] == 4'b1110) k = 0;
    if (v[9:6] == 4'b1101) k = 1;
    if (v[9:6] == 4'b1011) k = 2;
    if (v[9:6] == 4'b0111) k = 3;
    if (v[9:6] == 4'b1111) return;
    if (k < 0) begin
      eq.push_back(T);
      return;
    end
    if (T > m_last + TO) m_seen = 4'b0000;
    m_hex[k] = v[5:2];
    m_p[k]   = v[1];
    m_le[k]  = v[0];
    m_seen[k] = 1'b1;
    m_last = T;
    if (m_seen == 4'b1111) begin
      f.t    = T;
      f.hexs = {m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
      f.pt   = {m_p[3], m_p[2], m_p[1], m_p[0]};
      f.les  = {m_le[3], m_le[2], m_le[1], m_le[0]};
      fq.push_back(f);
      m_seen = 4'b0000;
    end
  endtask

  // Drive one pin value for L cycles (called at a negedge)
  task automatic seg(input logic [3:0] an, input logic [3:0] hx, input logic pp,
                     input logic le, input int L);
    logic [9:0] v;
    int c;
    v = {an, hx, pp, le};
    c = cyc;
    AN = an; Hex = hx; p = pp; LE = le;
    if (v != m_cur) begin
      m_cur = v;
      m_t0  = c + 1;
      m_cap = 1'b0;
    end
    if (!m_cap && (c + L >= m_t0 + SC)) begin
      m_cap = 1'b1;
      model_capture(m_t0 + SC, v);
    end
    repeat (L) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    AN = 4'b1111; Hex = 4'h0; p = 1'b0; LE = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_cur  = {4'b1111, 6'b000000};
    m_t0   = cyc;
    m_cap  = 1'b1;
    m_seen = 4'b0000;
    m_last = cyc;
    for (int k = 0; k < 4; k++) begin
      m_hex[k] = 4'h0; m_p[k] = 1'b0; m_le[k] = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_Hexs"}, Hexs, 0);
    chk({tag, "_point"}, point, 0);
    chk({tag, "_LES"}, LES, 0);
    chk({tag, "_frame_valid"}, frame_valid, 0);
    chk({tag, "_seen"}, seen, 0);
    chk({tag, "_err_illegal"}, err_illegal, 0);
    chk({tag, "_stalled"}, stalled, 0);
  endtask

  // Monitor: every frame_valid / err_illegal pulse must match the next expected event
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      if (fq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_frame cyc=%0d got Hexs=%h want no frame", cyc, Hexs);
      end else begin
        fpop = fq.pop_front();
        chk("frame_time", cyc, fpop.t);
        chk("frame_Hexs", Hexs, fpop.hexs);
        chk("frame_point", point, fpop.pt);
        chk("frame_LES", LES, fpop.les);
      end
    end
    if (err_illegal === 1'b1) begin
      if (eq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_err cyc=%0d got err_illegal=1 want 0", cyc);
      end else begin
        epop = eq.pop_front();
        chk("err_time", cyc, epop);
      end
    end
  end

  initial begin
    int c, n, r, k;
    logic [3:0] an;
    do_reset();
    chk_zero("reset");

    // 1: clean frame 0x1234, points 0101, LES 1010
    seg(4'b1110, 4'h4, 1'b1, 1'b0, 8);
    seg(4'b1101, 4'h3, 1'b0, 1'b1, 8);
    seg(4'b1011, 4'h2, 1'b1, 1'b0, 8);
    chk("t1_seen_partial", seen, 4'b0111);
    seg(4'b0111, 4'h1, 1'b0, 1'b1, 8);
    chk("t1_Hexs", Hexs, 16'h1234);
    chk("t1_point", point, 4'b0101);
    chk("t1_LES", LES, 4'b1010);
    chk("t1_seen", seen, 4'b0000);

    // 2: short glitch on slot 0 is not captured
    seg(4'b1110, 4'h5, 1'b0, 1'b0, 2);
    seg(4'b1101, 4'h6, 1'b1, 1'b1, 8);
    chk("t2_seen", seen, 4'b0010);

    // 3: illegal code raises one error pulse and changes nothing
    seg(4'b1100, 4'h7, 1'b0, 1'b0, 8);
    chk("t3_seen", seen, 4'b0010);
    chk("t3_Hexs", Hexs, 16'h1234);

    // 4: long blanking mid-frame, frame still completes
    seg(4'b1011, 4'h8, 1'b0, 1'b1, 8);
    seg(4'b1111, 4'h0, 1'b0, 1'b0, 100);
    chk("t4_stalled", stalled, 0);
    chk("t4_seen", seen, 4'b0110);
    seg(4'b0111, 4'h9, 1'b1, 1'b0, 8);
    seg(4'b1110, 4'hA, 1'b0, 1'b0, 8);
    chk("t4_Hexs", Hexs, 16'h986A);

    // 5: stall after a partial frame, then recovery
    seg(4'b1110, 4'h1, 1'b0, 1'b0, 8);
    seg(4'b1101, 4'h2, 1'b0, 1'b0, 8);
    c = cyc;
    seg(4'b1111, 4'h0, 1'b0, 1'b0, m_last + TO - 1 - c);
    chk("t5_stalled_before", stalled, 0);
    chk("t5_seen_before", seen, 4'b0011);
    seg(4'b1111, 4'h0, 1'b0, 1'b0, 1);
    chk("t5_stalled", stalled, 1);
    chk("t5_seen", seen, 4'b0000);
    seg(4'b1111, 4'h0, 1'b0, 1'b0, 20);
    chk("t5_stalled_hold", stalled, 1);
    seg(4'b1110, 4'h5, 1'b1, 1'b1, 8);
    chk("t5_stalled_clear", stalled, 0);
    seg(4'b1101, 4'h6, 1'b0, 1'b1, 8);
    seg(4'b1011, 4'h7, 1'b1, 1'b0, 8);
    seg(4'b0111, 4'h8, 1'b0, 1'b0, 8);
    chk("t5_Hexs", Hexs, 16'h8765);

    // 6: reset mid-frame discards partial frame
    seg(4'b1110, 4'h1, 1'b1, 1'b1, 8);
    seg(4'b1101, 4'h2, 1'b1, 1'b1, 8);
    seg(4'b1011, 4'h3, 1'b1, 1'b1, 8);
    do_reset();
    chk_zero("t6_reset");
    seg(4'b1110, 4'hD, 1'b0, 1'b1, 8);
    seg(4'b1101, 4'hC, 1'b1, 1'b0, 8);
    seg(4'b1011, 4'hB, 1'b0, 1'b1, 8);
    seg(4'b0111, 4'hA, 1'b1, 1'b0, 8);
    chk("t6_Hexs", Hexs, 16'hABCD);
    chk("t6_point", point, 4'b1010);
    chk("t6_LES", LES, 4'b0101);

    // Random scan with glitches, blanks and illegal codes
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 6) begin
        k  = $urandom_range(0, 3);
        an = 4'b1111;
        an[k] = 1'b0;
      end else if (r <= 8) begin
        an = 4'b1111;
      end else begin
        an = ill_codes[$urandom_range(0, 7)];
      end
      n = $urandom_range(1, 9);
      seg(an, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), n);
    end
    seg(4'b1111, 4'h0, 1'b0, 1'b0, 4);

    chk("pending_frames", fq.size(), 0);
    chk("pending_errs", eq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
